i2c_txn_sequencer: RTL and testbench
====================================

Name: i2c_txn_sequencer

Overview:
Transaction-level front end for the I2C byte engine (i2c_controller).
- Accepts one host command (7-bit address, direction, byte count).
- Breaks the command into START/WRITE/READ/STOP byte operations and issues them to the engine one at a time.
- Buffers read bytes and reports a completion status per command.
- Sits between the register/host interface and the engine.

Parameters:
LEN_W, 8, width of byte-count field; max transfer 2**LEN_W-1 bytes
RD_FIFO_DEPTH, 8, read-data buffer depth in bytes (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
srst_i  in  1  synchronous reset, active-high, same effect as rst_i
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_addr_i  in  7  slave address
cmd_rw_i  in  1  1=read, 0=write
cmd_len_i  in  LEN_W  data bytes; 0 = address-only probe
wr_data_i  in  8  write byte
wr_valid_i  in  1  write byte valid
wr_ready_o  out  1  write byte consumed when valid&ready
rd_data_o  out  8  read byte (FIFO head)
rd_valid_o  out  1  FIFO not empty
rd_ready_i  in  1  pop FIFO
done_o  out  1  one-cycle pulse, command finished
status_o  out  2  valid with done_o: 00 OK, 01 addr NACK, 10 data NACK, 11 arbitration lost
busy_o  out  1  state != IDLE
eng_req_valid_o  out  1  byte operation request to engine
eng_req_ready_i  in  1  engine accepts request
eng_req_op_o  out  2  OP_START, OP_WRITE, OP_READ, OP_STOP
eng_req_data_o  out  8  byte for START ({addr,rw}) or WRITE; 0 otherwise
eng_req_last_o  out  1  READ only: 1 = send NACK after byte
eng_rsp_valid_i  in  1  engine finished operation
eng_rsp_data_i  in  8  received byte (OP_READ)
eng_rsp_nack_i  in  1  slave NACKed (START/WRITE)
eng_rsp_arb_i  in  1  arbitration lost

Behaviour:
- Reset (rst_i or srst_i): state IDLE, FIFO emptied, all outputs 0 except cmd_ready_o=1. Mid-transaction reset drops everything: no STOP is issued and no done_o pulse.
- cmd_ready_o=1 only in IDLE. Acceptance latches addr, rw, len into a byte counter rem.
- Exactly one outstanding engine request. The sequencer holds req valid/op/data stable until req_ready, then waits for rsp_valid before the next request.
- States:
  - IDLE: on cmd accept -> START.
  - START: issue OP_START, data={addr,rw} -> WAIT_ADDR.
  - WAIT_ADDR, on rsp:
    - arb=1 -> FINISH(11), no STOP.
    - nack=1 -> STOP with status 01.
    - rem==0 -> STOP with status 00.
    - otherwise -> WR when rw=0, RD when rw=1.
  - WR: present OP_WRITE only while wr_valid_i=1. Data is wr_data_i, passed through combinationally. wr_ready_o = eng_req_ready_i in WR. On handshake, rem-- -> WAIT_WR.
  - WAIT_WR, on rsp:
    - arb -> FINISH(11).
    - nack -> STOP(10).
    - rem==0 -> STOP(00).
    - else -> WR.
  - RD: present OP_READ only while FIFO not full; last=(rem==1). On handshake, rem-- -> WAIT_RD.
  - WAIT_RD, on rsp: push eng_rsp_data_i into FIFO.
    - arb -> FINISH(11).
    - rem==0 -> STOP(00).
    - else -> RD.
  - STOP: issue OP_STOP -> WAIT_STOP. On rsp -> FINISH. Status is the one latched earlier; arb on the STOP response overrides it to 11.
  - FINISH: done_o=1 for one cycle -> IDLE.
- Data NACK on a write ends the transfer early; unsent write bytes stay unconsumed upstream.
- Read FIFO: push and pop in the same cycle are legal, including when full (pop frees the slot). Pop on empty is ignored. rd_valid_o is registered (FIFO not empty).
- eng_rsp_valid_i outside a WAIT_* state is ignored.
- No rem underflow: rem is only decremented when nonzero.

Decomposition:
- Package i2c_pkg: op enum (OP_START=0, OP_WRITE=1, OP_READ=2, OP_STOP=3), status enum (ST_OK, ST_ADDR_NACK, ST_DATA_NACK, ST_ARB_LOST), sequencer state enum. The package is shared with i2c_controller.
- One sub-module: i2c_sync_fifo (WIDTH=8, DEPTH=RD_FIFO_DEPTH) holds the read data.

Test Plan:
- Write 0x50, len=3, data A1,B2,C3, engine always ACKs -> engine sees START 0xA0, WRITE A1/B2/C3, STOP; done_o with status 00; wr_ready_o pulses exactly 3 times.
- Read 0x68, len=4, engine returns 11,22,33,44 -> START 0xD1, 4 READs with last=0,0,0,1, STOP; FIFO outputs 11,22,33,44; status 00.
- Probe 0x3C, len=0, addr NACK -> START 0x78 then STOP; status 01; no WRITE/READ issued.
- Write len=5, NACK on 2nd data byte -> STOP after 2 writes; status 10; only 2 write bytes consumed.
- Read len=10, RD_FIFO_DEPTH=8, rd_ready_i=0 -> exactly 8 READs issued, then stall. Raise rd_ready_i -> remaining 2 READs issued, 10 bytes delivered in order.
- Arbitration loss on START response -> no STOP issued; done_o with status 11. Then assert rst_i mid-read on a new command -> cmd_ready_o=1, rd_valid_o=0, no done_o pulse.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C byte engine and its transaction sequencer.
package i2c_pkg;

   typedef enum logic [1:0] {
      OP_START = 2'd0,
      OP_WRITE = 2'd1,
      OP_READ  = 2'd2,
      OP_STOP  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_OK        = 2'd0,
      ST_ADDR_NACK = 2'd1,
      ST_DATA_NACK = 2'd2,
      ST_ARB_LOST  = 2'd3
   } status_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_WAIT_ADDR,
      S_WR,
      S_WAIT_WR,
      S_RD,
      S_WAIT_RD,
      S_STOP,
      S_WAIT_STOP,
      S_FINISH
   } seq_state_e;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO; simultaneous push and pop are legal even when full.
module i2c_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             srst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop_i && (count != '0);
   // A pop in the same cycle frees the slot the push needs.
   assign do_push = push_i && ((count != FULL_CNT) || do_pop);

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (srst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign valid_o = (count != '0);
   assign full_o  = (count == FULL_CNT);
   assign data_o  = valid_o ? mem[rd_ptr] : '0;

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Splits one host I2C command into START/WRITE/READ/STOP engine operations,
// buffers read bytes and reports a per-command completion status.
module i2c_txn_sequencer
   import i2c_pkg::*;
#(
   parameter int LEN_W         = 8,
   parameter int RD_FIFO_DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             srst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [6:0]       cmd_addr_i,
   input  logic             cmd_rw_i,
   input  logic [LEN_W-1:0] cmd_len_i,
   input  logic [7:0]       wr_data_i,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   output logic [7:0]       rd_data_o,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic             done_o,
   output logic [1:0]       status_o,
   output logic             busy_o,
   output logic             eng_req_valid_o,
   input  logic             eng_req_ready_i,
   output logic [1:0]       eng_req_op_o,
   output logic [7:0]       eng_req_data_o,
   output logic             eng_req_last_o,
   input  logic             eng_rsp_valid_i,
   input  logic [7:0]       eng_rsp_data_i,
   input  logic             eng_rsp_nack_i,
   input  logic             eng_rsp_arb_i
);

   seq_state_e       state, state_nxt;
   logic [6:0]       addr_q, addr_nxt;
   logic             rw_q, rw_nxt;
   logic [LEN_W-1:0] rem_q, rem_nxt;
   status_e          status_q, status_nxt;
   logic             fifo_push;
   logic             fifo_full;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         rw_q     <= 1'b0;
         rem_q    <= '0;
         status_q <= ST_OK;
      end else if (srst_i) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         rw_q     <= 1'b0;
         rem_q    <= '0;
         status_q <= ST_OK;
      end else begin
         state    <= state_nxt;
         addr_q   <= addr_nxt;
         rw_q     <= rw_nxt;
         rem_q    <= rem_nxt;
         status_q <= status_nxt;
      end
   end

   // Request fields are decoded from the registered state, so they stay
   // stable until eng_req_ready_i; only one operation is ever outstanding.
   always_comb begin
      state_nxt       = state;
      addr_nxt        = addr_q;
      rw_nxt          = rw_q;
      rem_nxt         = rem_q;
      status_nxt      = status_q;
      cmd_ready_o     = 1'b0;
      wr_ready_o      = 1'b0;
      done_o          = 1'b0;
      status_o        = 2'b00;
      eng_req_valid_o = 1'b0;
      eng_req_op_o    = OP_START;
      eng_req_data_o  = '0;
      eng_req_last_o  = 1'b0;
      fifo_push       = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               addr_nxt   = cmd_addr_i;
               rw_nxt     = cmd_rw_i;
               rem_nxt    = cmd_len_i;
               status_nxt = ST_OK;
               state_nxt  = S_START;
            end
         end
         S_START: begin
            eng_req_valid_o = 1'b1;
            eng_req_op_o    = OP_START;
            eng_req_data_o  = {addr_q, rw_q};
            if (eng_req_ready_i) state_nxt = S_WAIT_ADDR;
         end
         S_WAIT_ADDR: begin
            if (eng_rsp_valid_i) begin
               if (eng_rsp_arb_i) begin
                  status_nxt = ST_ARB_LOST;
                  state_nxt  = S_FINISH;
               end else if (eng_rsp_nack_i) begin
                  status_nxt = ST_ADDR_NACK;
                  state_nxt  = S_STOP;
               end else if (rem_q == '0) begin
                  state_nxt = S_STOP;
               end else begin
                  state_nxt = rw_q ? S_RD : S_WR;
               end
            end
         end
         S_WR: begin
            wr_ready_o      = eng_req_ready_i;
            eng_req_valid_o = wr_valid_i;
            eng_req_op_o    = OP_WRITE;
            eng_req_data_o  = wr_valid_i ? wr_data_i : 8'h00;
            if (wr_valid_i && eng_req_ready_i) begin
               if (rem_q != '0) rem_nxt = rem_q - LEN_W'(1);
               state_nxt = S_WAIT_WR;
            end
         end
         S_WAIT_WR: begin
            if (eng_rsp_valid_i) begin
               if (eng_rsp_arb_i) begin
                  status_nxt = ST_ARB_LOST;
                  state_nxt  = S_FINISH;
               end else if (eng_rsp_nack_i) begin
                  status_nxt = ST_DATA_NACK;
                  state_nxt  = S_STOP;
               end else if (rem_q == '0) begin
                  state_nxt = S_STOP;
               end else begin
                  state_nxt = S_WR;
               end
            end
         end
         S_RD: begin
            eng_req_valid_o = !fifo_full;
            eng_req_op_o    = OP_READ;
            eng_req_last_o  = (rem_q == LEN_W'(1));
            if (!fifo_full && eng_req_ready_i) begin
               if (rem_q != '0) rem_nxt = rem_q - LEN_W'(1);
               state_nxt = S_WAIT_RD;
            end
         end
         S_WAIT_RD: begin
            if (eng_rsp_valid_i) begin
               fifo_push = 1'b1;
               if (eng_rsp_arb_i) begin
                  status_nxt = ST_ARB_LOST;
                  state_nxt  = S_FINISH;
               end else if (rem_q == '0) begin
                  state_nxt = S_STOP;
               end else begin
                  state_nxt = S_RD;
               end
            end
         end
         S_STOP: begin
            eng_req_valid_o = 1'b1;
            eng_req_op_o    = OP_STOP;
            if (eng_req_ready_i) state_nxt = S_WAIT_STOP;
         end
         S_WAIT_STOP: begin
            if (eng_rsp_valid_i) begin
               if (eng_rsp_arb_i) status_nxt = ST_ARB_LOST;
               state_nxt = S_FINISH;
            end
         end
         S_FINISH: begin
            done_o    = 1'b1;
            status_o  = status_q;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy_o = (state != S_IDLE);

   i2c_sync_fifo #(
      .WIDTH (8),
      .DEPTH (RD_FIFO_DEPTH)
   ) u_rd_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .srst_i  (srst_i),
      .push_i  (fifo_push),
      .data_i  (eng_rsp_data_i),
      .pop_i   (rd_ready_i),
      .data_o  (rd_data_o),
      .valid_o (rd_valid_o),
      .full_o  (fifo_full)
   );

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: a randomly-timed engine/host agent plus a
// command-level reference model of the expected operation stream.
module tb_i2c_txn_sequencer;
   import i2c_pkg::*;

   localparam int LEN_W = 8;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst_i, srst_i;
   logic             cmd_valid_i, cmd_ready_o;
   logic [6:0]       cmd_addr_i;
   logic             cmd_rw_i;
   logic [LEN_W-1:0] cmd_len_i;
   logic [7:0]       wr_data_i;
   logic             wr_valid_i, wr_ready_o;
   logic [7:0]       rd_data_o;
   logic             rd_valid_o, rd_ready_i;
   logic             done_o;
   logic [1:0]       status_o;
   logic             busy_o;
   logic             eng_req_valid_o, eng_req_ready_i;
   logic [1:0]       eng_req_op_o;
   logic [7:0]       eng_req_data_o;
   logic             eng_req_last_o;
   logic             eng_rsp_valid_i;
   logic [7:0]       eng_rsp_data_i;
   logic             eng_rsp_nack_i, eng_rsp_arb_i;

   always #5 clk = ~clk;

   i2c_txn_sequencer #(.LEN_W(LEN_W), .RD_FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst_i), .srst_i(srst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_addr_i(cmd_addr_i), .cmd_rw_i(cmd_rw_i), .cmd_len_i(cmd_len_i),
      .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
      .done_o(done_o), .status_o(status_o), .busy_o(busy_o),
      .eng_req_valid_o(eng_req_valid_o), .eng_req_ready_i(eng_req_ready_i),
      .eng_req_op_o(eng_req_op_o), .eng_req_data_o(eng_req_data_o),
      .eng_req_last_o(eng_req_last_o), .eng_rsp_valid_i(eng_rsp_valid_i),
      .eng_rsp_data_i(eng_rsp_data_i), .eng_rsp_nack_i(eng_rsp_nack_i),
      .eng_rsp_arb_i(eng_rsp_arb_i)
   );

   // fk: 0 none, 1 NACK, 2 arbitration lost, injected on engine op index fi
   typedef struct {
      bit         rw;
      logic [6:0] addr;
      int         len;
      int         fk;
      int         fi;
      logic [1:0] exp_status;
      int         exp_nops;
   } vec_t;

   int n_vec = 0;
   int n_miss = 0;

   // main-owned controls
   bit         rd_mode, wr_mode;
   int         fault_kind, fault_idx;
   int         cmd_seq;
   logic [7:0] rd_src [0:255];
   logic [7:0] wr_src [0:255];

   // agent-owned observations
   int          op_cnt, rd_op_cnt, wr_ptr, done_cnt;
   logic [1:0]  done_status;
   logic [10:0] obs_q[$];
   logic [7:0]  got_q[$];

   // model outputs
   logic [10:0] exp_ops[$];
   logic [1:0]  exp_status;
   int          exp_wr, exp_rd, done_base;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Engine, write source and read sink. Inputs change 1 time unit after the
   // rising edge; handshakes are observed at the falling edge.
   initial begin
      bit         hs, pending;
      int         delay, seen_seq;
      logic       p_nack, p_arb;
      logic [7:0] p_data;
      pending = 0; delay = 0; seen_seq = 0;
      p_nack = 0; p_arb = 0; p_data = 0;
      op_cnt = 0; rd_op_cnt = 0; wr_ptr = 0; done_cnt = 0; done_status = 0;
      eng_req_ready_i = 0; eng_rsp_valid_i = 0; eng_rsp_data_i = 0;
      eng_rsp_nack_i = 0; eng_rsp_arb_i = 0;
      wr_valid_i = 0; wr_data_i = 0; rd_ready_i = 0;
      forever begin
         @(negedge clk);
         if (cmd_seq != seen_seq) begin
            seen_seq = cmd_seq;
            op_cnt = 0; rd_op_cnt = 0; wr_ptr = 0;
            obs_q.delete(); got_q.delete();
         end
         hs = eng_req_valid_o && eng_req_ready_i;
         if (hs) begin
            obs_q.push_back({eng_req_op_o, eng_req_data_o, eng_req_last_o});
            p_nack = (fault_kind == 1) && (op_cnt == fault_idx);
            p_arb  = (fault_kind == 2) && (op_cnt == fault_idx);
            if (eng_req_op_o == OP_READ) begin
               p_data = rd_src[rd_op_cnt];
               rd_op_cnt++;
            end else p_data = 8'($urandom);
            op_cnt++;
         end
         if (wr_valid_i && wr_ready_o) wr_ptr++;
         if (rd_valid_o && rd_ready_i) got_q.push_back(rd_data_o);
         if (done_o) begin
            done_cnt++;
            done_status = status_o;
         end
         @(posedge clk); #1;
         eng_rsp_valid_i = 0; eng_rsp_nack_i = 0; eng_rsp_arb_i = 0;
         eng_rsp_data_i = 8'($urandom);
         if (rst_i || srst_i) pending = 0;
         else if (hs) begin
            pending = 1;
            delay = $urandom_range(0, 2);
         end
         if (pending) begin
            if (delay == 0) begin
               eng_rsp_valid_i = 1; eng_rsp_nack_i = p_nack;
               eng_rsp_arb_i = p_arb; eng_rsp_data_i = p_data;
               pending = 0;
            end else delay--;
         end else if (!hs && $urandom_range(0, 5) == 0) begin
            // stray response outside any wait state
            eng_rsp_valid_i = 1; eng_rsp_nack_i = 1; eng_rsp_arb_i = 1;
         end
         eng_req_ready_i = !pending && ($urandom_range(0, 3) != 0);
         wr_valid_i = wr_mode && ($urandom_range(0, 3) != 0);
         wr_data_i  = wr_src[wr_ptr];
         rd_ready_i = rd_mode && ($urandom_range(0, 1) == 1);
      end
   end

   // Expected op stream from the command rules: START, then one op per data
   // byte until a fault ends it, then STOP unless arbitration was lost.
   task automatic model(input bit rw, input logic [6:0] addr, input int len,
                        input int fk, input int fi);
      exp_ops.delete();
      exp_status = 2'd0; exp_wr = 0; exp_rd = 0;
      exp_ops.push_back({OP_START, addr, rw, 1'b0});
      if (fi == 0 && fk == 2) begin
         exp_status = 2'd3;
         return;
      end
      if (fi == 0 && fk == 1) exp_status = 2'd1;
      else begin
         for (int i = 0; i < len; i++) begin
            if (rw) begin
               exp_ops.push_back({OP_READ, 8'h00, (i == len - 1)});
               exp_rd++;
            end else begin
               exp_ops.push_back({OP_WRITE, wr_src[i], 1'b0});
               exp_wr++;
            end
            if (fi == i + 1 && fk == 2) begin
               exp_status = 2'd3;
               return;
            end
            if (fi == i + 1 && fk == 1 && !rw) begin
               exp_status = 2'd2;
               break;
            end
         end
      end
      if (fi == exp_ops.size() && fk == 2) exp_status = 2'd3;
      exp_ops.push_back({OP_STOP, 8'h00, 1'b0});
   endtask

   task automatic start_cmd(input bit rw, input logic [6:0] addr, input int len,
                            input int fk, input int fi);
      bit accepted;
      @(posedge clk); #2;
      fault_kind = fk; fault_idx = fi;
      cmd_seq++;
      model(rw, addr, len, fk, fi);
      done_base = done_cnt;
      cmd_valid_i = 1; cmd_addr_i = addr; cmd_rw_i = rw; cmd_len_i = LEN_W'(len);
      accepted = 0;
      for (int c = 0; c < 50 && !accepted; c++) begin
         @(negedge clk);
         if (cmd_ready_o) accepted = 1;
         @(posedge clk); #2;
      end
      cmd_valid_i = 0;
      chk("cmd_accept", 32'(accepted), 32'd1);
   endtask

   task automatic finish_cmd(input string tag, input int budget);
      bit got;
      int n;
      got = 0;
      for (int c = 0; c < budget && !got; c++) begin
         @(posedge clk);
         if (done_cnt != done_base) got = 1;
      end
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      for (int c = 0; c < 500 && got_q.size() < exp_rd; c++) @(posedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk({tag, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
      chk({tag, "_status"}, 32'(done_status), 32'(exp_status));
      chk({tag, "_nops"}, 32'(obs_q.size()), 32'(exp_ops.size()));
      n = (obs_q.size() < exp_ops.size()) ? obs_q.size() : exp_ops.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_op%0d", tag, i), 32'(obs_q[i]), 32'(exp_ops[i]));
      chk({tag, "_wr_consumed"}, 32'(wr_ptr), 32'(exp_wr));
      chk({tag, "_rd_count"}, 32'(got_q.size()), 32'(exp_rd));
      n = (got_q.size() < exp_rd) ? got_q.size() : exp_rd;
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_rd%0d", tag, i), 32'(got_q[i]), 32'(rd_src[i]));
      chk({tag, "_idle"}, 32'({busy_o, cmd_ready_o}), 32'b01);
   endtask

   task automatic mid_reset(input bit use_srst);
      bit reached;
      string tag;
      tag = use_srst ? "srst" : "arst";
      rd_mode = 0;
      start_cmd(1'b1, 7'h66, 6, 0, -1);
      reached = 0;
      for (int c = 0; c < 1000 && !reached; c++) begin
         @(posedge clk);
         if (obs_q.size() >= 3) reached = 1;
      end
      chk({tag, "_reached"}, 32'(reached), 32'd1);
      @(posedge clk); #2;
      if (use_srst) srst_i = 1; else rst_i = 1;
      repeat (3) @(posedge clk);
      #2; rst_i = 0; srst_i = 0;
      repeat (5) @(negedge clk);
      chk({tag, "_no_done"}, 32'(done_cnt), 32'(done_base));
      chk({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
      chk({tag, "_rd_valid"}, 32'(rd_valid_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_req_valid"}, 32'(eng_req_valid_o), 32'd0);
      rd_mode = 1;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      bit   reached;
      vecs[0] = '{0, 7'h50, 3, 0, -1, 2'd0, 5};  // write, all ACK
      vecs[1] = '{1, 7'h68, 4, 0, -1, 2'd0, 6};  // read, all ACK
      vecs[2] = '{0, 7'h3C, 0, 1,  0, 2'd1, 2};  // probe, addr NACK
      vecs[3] = '{0, 7'h2A, 5, 1,  2, 2'd2, 4};  // NACK on 2nd data byte
      vecs[4] = '{0, 7'h11, 2, 2,  0, 2'd3, 1};  // arb lost on START
      vecs[5] = '{1, 7'h22, 3, 2,  2, 2'd3, 3};  // arb lost on 2nd READ
      vecs[6] = '{0, 7'h33, 2, 2,  3, 2'd3, 4};  // arb lost on STOP
      vecs[7] = '{1, 7'h44, 2, 1,  1, 2'd0, 4};  // NACK on READ is ignored

      cmd_valid_i = 0; cmd_addr_i = 0; cmd_rw_i = 0; cmd_len_i = 0;
      rst_i = 1; srst_i = 0; rd_mode = 1; wr_mode = 1;
      fault_kind = 0; fault_idx = -1; cmd_seq = 0;
      for (int i = 0; i < 256; i++) begin
         wr_src[i] = 8'(8'hA1 + i * 17);
         rd_src[i] = 8'((i + 1) * 17);
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
      chk("rst_outputs", 32'({busy_o, done_o, rd_valid_o, eng_req_valid_o, wr_ready_o, status_o}), 32'd0);
      @(posedge clk); #2;
      rst_i = 0;

      for (int v = 0; v < 8; v++) begin
         start_cmd(vecs[v].rw, vecs[v].addr, vecs[v].len, vecs[v].fk, vecs[v].fi);
         finish_cmd($sformatf("vec%0d", v), 2000);
         chk($sformatf("vec%0d_tbl_status", v), 32'(done_status), 32'(vecs[v].exp_status));
         chk($sformatf("vec%0d_tbl_nops", v), 32'(obs_q.size()), 32'(vecs[v].exp_nops));
      end

      // read longer than the FIFO with nobody popping: must stall at full
      rd_mode = 0;
      start_cmd(1'b1, 7'h55, 10, 0, -1);
      reached = 0;
      for (int c = 0; c < 2000 && !reached; c++) begin
         @(posedge clk);
         if (obs_q.size() >= 1 + DEPTH) reached = 1;
      end
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("stall_reached", 32'(reached), 32'd1);
      chk("stall_ops", 32'(obs_q.size()), 32'(1 + DEPTH));
      chk("stall_rd_valid", 32'(rd_valid_o), 32'd1);
      chk("stall_busy", 32'(busy_o), 32'd1);
      chk("stall_no_done", 32'(done_cnt), 32'(done_base));
      rd_mode = 1;
      finish_cmd("stall", 3000);

      mid_reset(1'b0);
      mid_reset(1'b1);

      for (int r = 0; r < 20; r++) begin
         bit         rw;
         logic [6:0] addr;
         int         len, fk, fi;
         rw   = 1'($urandom_range(0, 1));
         addr = 7'($urandom);
         len  = $urandom_range(0, 12);
         fk   = $urandom_range(0, 2);
         fi   = (fk != 0) ? $urandom_range(0, len + 1) : -1;
         for (int i = 0; i < 16; i++) begin
            wr_src[i] = 8'($urandom);
            rd_src[i] = 8'($urandom);
         end
         start_cmd(rw, addr, len, fk, fi);
         finish_cmd($sformatf("rnd%0d", r), 3000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
